// File: rtl/nn_weight_sng.sv
// Stochastic number generator bank: N signed weights plus one signed bias are
// turned into unipolar bitstreams (with sign lines) over exact 2^BW-1 windows.
module nn_weight_sng #(
  parameter int unsigned N  = 4,
  parameter int unsigned BW = 8
) (
  input  logic            CLK,
  input  logic            INIT,
  input  logic            LOAD,
  input  logic [N*BW-1:0] W_MAG,
  input  logic [N-1:0]    W_SIGN,
  input  logic [BW-1:0]   B_MAG,
  input  logic            B_SIGN,
  input  logic            START,
  input  logic            CONT,
  output logic [N-1:0]    alpha,
  output logic [N-1:0]    SIGN_alpha,
  output logic            beta,
  output logic            SIGN_beta,
  output logic            FRAME,
  output logic            DONE,
  output logic            BUSY
);

  // Lane N is the bias lane; lanes 0..N-1 are the weights.
  localparam int unsigned LANES = N + 1;

  // Last WCNT value of a window (window length is 2^BW-1 cycles).
  localparam logic [BW-1:0] WCNT_LAST = BW'((1 << BW) - 2);

  // Right-shift Galois feedback masks for the maximal-length polynomials.
  localparam logic [BW-1:0] TAPS = (BW == 4) ? BW'(4'hC)  :
                                   (BW == 6) ? BW'(6'h30) :
                                               BW'(8'hB8);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [BW-1:0]   wcnt;
  logic            pend;
  logic [BW-1:0]   lfsr     [LANES];
  logic [BW-1:0]   sh_mag   [LANES];
  logic [LANES-1:0] sh_sign;
  logic [BW-1:0]   act_mag  [LANES];
  logic [LANES-1:0] act_sign;
  logic [BW-1:0]   in_mag   [LANES];
  logic [LANES-1:0] in_sign;

  logic            start_win;
  logic            last_cyc;
  logic            do_copy;
  logic            do_bypass;

  // Per-lane seed: 2k+1 truncated to BW bits, never zero.
  function automatic logic [BW-1:0] seed_of(input int unsigned k);
    logic [BW-1:0] s;
    s = BW'(2 * k + 1);
    if (s == '0) begin
      s = BW'(1);
    end
    return s;
  endfunction

  // One Galois step; a nonzero state never maps to zero.
  function automatic logic [BW-1:0] lfsr_step(input logic [BW-1:0] v);
    logic [BW-1:0] n;
    n = v >> 1;
    if (v[0]) begin
      n = n ^ TAPS;
    end
    return n;
  endfunction

  // Unpack the load bus into per-lane magnitudes and signs.
  always_comb begin
    for (int k = 0; k < int'(N); k++) begin
      in_mag[k] = W_MAG[k*BW +: BW];
    end
    in_mag[N] = B_MAG;
    in_sign   = {B_SIGN, W_SIGN};
  end

  // State register.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and window control decode.
  always_comb begin
    state_next = state;
    start_win  = 1'b0;
    last_cyc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_next = ST_RUN;
          start_win  = 1'b1;
        end
      end
      ST_RUN: begin
        if (wcnt == WCNT_LAST) begin
          last_cyc = 1'b1;
          if (!CONT) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    // Shadow-to-active copy only at window boundaries or while idle.
    do_copy   = pend && ((state == ST_IDLE) || last_cyc);
    // LOAD together with START: the new window takes the freshly loaded values.
    do_bypass = start_win && LOAD;
  end

  // Window counter: cleared on window start and at each window boundary.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      wcnt <= '0;
    end else if (start_win) begin
      wcnt <= '0;
    end else if (state == ST_RUN) begin
      if (last_cyc) begin
        wcnt <= '0;
      end else begin
        wcnt <= wcnt + BW'(1);
      end
    end
  end

  // LFSR bank: reseeded on START, free-running in RUN; a full period equals one window.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      for (int k = 0; k < int'(LANES); k++) begin
        lfsr[k] <= seed_of(k);
      end
    end else if (start_win) begin
      for (int k = 0; k < int'(LANES); k++) begin
        lfsr[k] <= seed_of(k);
      end
    end else if (state == ST_RUN) begin
      for (int k = 0; k < int'(LANES); k++) begin
        lfsr[k] <= lfsr_step(lfsr[k]);
      end
    end
  end

  // Pending flag: a LOAD wins over a same-edge copy so the newest values stay queued.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      pend <= 1'b0;
    end else if (do_bypass) begin
      pend <= 1'b0;
    end else if (LOAD) begin
      pend <= 1'b1;
    end else if (do_copy) begin
      pend <= 1'b0;
    end
  end

  // Shadow register set, written by LOAD at any time.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      for (int k = 0; k < int'(LANES); k++) begin
        sh_mag[k] <= '0;
      end
      sh_sign <= '0;
    end else if (LOAD) begin
      for (int k = 0; k < int'(LANES); k++) begin
        sh_mag[k] <= in_mag[k];
      end
      sh_sign <= in_sign;
    end
  end

  // Active register set; only updated between windows.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      for (int k = 0; k < int'(LANES); k++) begin
        act_mag[k] <= '0;
      end
      act_sign <= '0;
    end else if (do_bypass) begin
      for (int k = 0; k < int'(LANES); k++) begin
        act_mag[k] <= in_mag[k];
      end
      act_sign <= in_sign;
    end else if (do_copy) begin
      for (int k = 0; k < int'(LANES); k++) begin
        act_mag[k] <= sh_mag[k];
      end
      act_sign <= sh_sign;
    end
  end

  // Output decode, from flops only.
  always_comb begin
    FRAME = (state == ST_RUN);
    BUSY  = (state == ST_RUN);
    DONE  = (state == ST_RUN) && (wcnt == WCNT_LAST);
    for (int k = 0; k < int'(N); k++) begin
      alpha[k] = FRAME && (lfsr[k] <= act_mag[k]);
    end
    beta       = FRAME && (lfsr[N] <= act_mag[N]);
    SIGN_alpha = act_sign[N-1:0];
    SIGN_beta  = act_sign[N];
  end

endmodule

// File: tb/tb_nn_weight_sng.sv
// Scoreboard bench for nn_weight_sng: expected per-window ones counts are queued
// at stimulus time and popped by a monitor on every DONE.
module tb_nn_weight_sng;

  logic        CLK;
  logic        INIT;
  logic        LOAD;
  logic [31:0] W_MAG;
  logic [3:0]  W_SIGN;
  logic [7:0]  B_MAG;
  logic        B_SIGN;
  logic        START;
  logic        CONT;
  logic [3:0]  alpha;
  logic [3:0]  SIGN_alpha;
  logic        beta;
  logic        SIGN_beta;
  logic        FRAME;
  logic        DONE;
  logic        BUSY;

  nn_weight_sng #(.N(4), .BW(8)) dut (
    .CLK(CLK), .INIT(INIT), .LOAD(LOAD), .W_MAG(W_MAG), .W_SIGN(W_SIGN),
    .B_MAG(B_MAG), .B_SIGN(B_SIGN), .START(START), .CONT(CONT),
    .alpha(alpha), .SIGN_alpha(SIGN_alpha), .beta(beta), .SIGN_beta(SIGN_beta),
    .FRAME(FRAME), .DONE(DONE), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0][8:0] cnt;
    logic [8:0]      bcnt;
    logic [3:0]      sa;
    logic            sb;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;

  int         cnt [4];
  int         bcnt;
  int         flen;
  int         cyc;
  int         last_done;
  int         done_gap;
  int         win_count;
  logic [4:0] cur_bits  [255];
  logic [4:0] last_bits [255];
  logic [4:0] ref_bits  [255];

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic clear_win();
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    bcnt = 0;
    flen = 0;
  endtask

  // Monitor: accumulate stream bits, score each window on DONE.
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (!INIT) begin
      clear_win();
    end else if (FRAME) begin
      if (flen < 255) cur_bits[flen] = {beta, alpha};
      for (int k = 0; k < 4; k++) cnt[k] += int'(alpha[k]);
      bcnt += int'(beta);
      flen++;
      if (DONE) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: window %0d has no expected entry", win_count);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < 4; k++)
            chk($sformatf("win%0d_lane%0d_ones", win_count, k), cnt[k], int'(e.cnt[k]));
          chk($sformatf("win%0d_beta_ones", win_count), bcnt, int'(e.bcnt));
          chk($sformatf("win%0d_sign_alpha", win_count), int'(SIGN_alpha), int'(e.sa));
          chk($sformatf("win%0d_sign_beta", win_count), int'(SIGN_beta), int'(e.sb));
          chk($sformatf("win%0d_frame_len", win_count), flen, 255);
        end
        last_bits = cur_bits;
        done_gap  = cyc - last_done;
        last_done = cyc;
        win_count++;
        clear_win();
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] wm, input logic [3:0] ws,
                          input logic [7:0] bm, input logic bs);
    exp_t e;
    for (int k = 0; k < 4; k++) e.cnt[k] = 9'(wm[k*8 +: 8]);
    e.bcnt = 9'(bm);
    e.sa   = ws;
    e.sb   = bs;
    exp_q.push_back(e);
  endtask

  task automatic do_load(input logic [31:0] wm, input logic [3:0] ws,
                         input logic [7:0] bm, input logic bs, input logic st);
    W_MAG  = wm;
    W_SIGN = ws;
    B_MAG  = bm;
    B_SIGN = bs;
    LOAD   = 1'b1;
    START  = st;
    tick();
    LOAD   = 1'b0;
    START  = 1'b0;
  endtask

  task automatic wait_win(input int target);
    int n;
    n = 0;
    while (win_count < target && n < 600) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (win_count < target) begin
      checks++;
      failures++;
      $display("FAIL timeout: windows seen %0d required %0d", win_count, target);
    end
  endtask

  localparam logic [31:0] T1 = {8'd255, 8'd128, 8'd1, 8'd0};

  initial begin
    int saved;
    int mism;
    checks = 0; failures = 0; cyc = 0; last_done = 0; done_gap = 0; win_count = 0;
    clear_win();
    INIT = 1'b0; LOAD = 1'b0; START = 1'b0; CONT = 1'b0;
    W_MAG = '0; W_SIGN = '0; B_MAG = '0; B_SIGN = 1'b0;
    repeat (3) tick();
    chk("rst_alpha", int'(alpha), 0);
    chk("rst_beta", int'(beta), 0);
    chk("rst_signs", int'({SIGN_alpha, SIGN_beta}), 0);
    chk("rst_ctrl", int'({FRAME, DONE, BUSY}), 0);
    INIT = 1'b1;
    tick();

    // Window 0: magnitudes {0,1,128,255}, LOAD then START.
    push_exp(T1, 4'b0000, 8'd0, 1'b0);
    do_load(T1, 4'b0000, 8'd0, 1'b0, 1'b0);
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("w0_frame_after_start", int'(FRAME), 1);
    wait_win(1);
    tick();
    chk("w0_busy_falls", int'(BUSY), 0);
    chk("w0_frame_falls", int'(FRAME), 0);
    ref_bits = last_bits;

    // Window 1: signs and bias, LOAD together with START.
    push_exp({8'd77, 8'd200, 8'd13, 8'd64}, 4'b1010, 8'd64, 1'b1);
    do_load({8'd77, 8'd200, 8'd13, 8'd64}, 4'b1010, 8'd64, 1'b1, 1'b1);
    chk("w1_sign_alpha", int'(SIGN_alpha), 4'b1010);
    chk("w1_sign_beta", int'(SIGN_beta), 1);
    wait_win(2);
    tick();

    // Windows 2-3: CONT held, lane0 reloaded mid-window.
    push_exp({8'd33, 8'd250, 8'd5, 8'd10}, 4'b0000, 8'd7, 1'b0);
    push_exp({8'd33, 8'd250, 8'd5, 8'd200}, 4'b0000, 8'd7, 1'b0);
    CONT = 1'b1;
    do_load({8'd33, 8'd250, 8'd5, 8'd10}, 4'b0000, 8'd7, 1'b0, 1'b1);
    repeat (100) tick();
    do_load({8'd33, 8'd250, 8'd5, 8'd200}, 4'b0000, 8'd7, 1'b0, 1'b0);
    wait_win(3);
    tick();
    CONT = 1'b0;
    chk("w3_no_gap_frame", int'(FRAME), 1);
    wait_win(4);
    chk("w3_done_spacing", done_gap, 255);
    tick();
    chk("w3_busy_falls", int'(BUSY), 0);

    // Window 4: pending mid-window LOAD, then LOAD on the last cycle.
    push_exp({8'd50, 8'd50, 8'd50, 8'd50}, 4'b0011, 8'd50, 1'b0);
    do_load({8'd50, 8'd50, 8'd50, 8'd50}, 4'b0011, 8'd50, 1'b0, 1'b1);
    repeat (10) tick();
    do_load({8'd60, 8'd60, 8'd60, 8'd60}, 4'b1000, 8'd60, 1'b0, 1'b0);
    repeat (243) tick();
    do_load({8'd1, 8'd2, 8'd254, 8'd100}, 4'b0101, 8'd9, 1'b1, 1'b0);
    wait_win(5);
    tick();
    chk("w4_sign_alpha_after_copy", int'(SIGN_alpha), 4'b0101);
    chk("w4_sign_beta_after_copy", int'(SIGN_beta), 1);
    chk("w4_pend_clear", int'(dut.pend), 0);
    push_exp({8'd1, 8'd2, 8'd254, 8'd100}, 4'b0101, 8'd9, 1'b1);
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_win(6);
    tick();

    // Abort by reset at WCNT=50; restart must repeat the power-up sequence.
    do_load(T1, 4'b1111, 8'd200, 1'b1, 1'b1);
    repeat (50) tick();
    saved = win_count;
    INIT = 1'b0;
    #1;
    chk("abort_alpha", int'(alpha), 0);
    chk("abort_beta", int'(beta), 0);
    chk("abort_signs", int'({SIGN_alpha, SIGN_beta}), 0);
    chk("abort_ctrl", int'({FRAME, DONE, BUSY}), 0);
    repeat (3) tick();
    INIT = 1'b1;
    tick();
    chk("abort_no_done", win_count, saved);
    push_exp(T1, 4'b0000, 8'd0, 1'b0);
    do_load(T1, 4'b0000, 8'd0, 1'b0, 1'b1);
    wait_win(saved + 1);
    mism = 0;
    for (int i = 0; i < 255; i++) if (last_bits[i] !== ref_bits[i]) mism++;
    chk("reset_reseq_mismatches", mism, 0);
    tick();

    // START mid-window is ignored; window still ends at 255 cycles.
    push_exp({8'd249, 8'd199, 8'd99, 8'd9}, 4'b0000, 8'd128, 1'b0);
    do_load({8'd249, 8'd199, 8'd99, 8'd9}, 4'b0000, 8'd128, 1'b0, 1'b1);
    repeat (20) tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_win(saved + 2);
    tick();
    chk("start_in_run_busy_falls", int'(BUSY), 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nn_weight_sng.md
# nn_weight_sng

Stochastic number generator bank that feeds a polar neural node. It converts N signed sign-magnitude binary weights, plus one signed bias, into unipolar bitstreams with separate sign lines. Per-lane LFSRs drive the streams. Bitstreams are emitted over fixed, exactly-counted windows. The outputs connect directly to the node's `alpha`, `SIGN_alpha`, `beta` and `SIGN_beta` inputs.

## Interface
Parameters:
- `N`, 4, number of weight lanes.
- `BW`, 8, magnitude width. Supported values: 4, 6, 8. Window length is 2^BW−1 cycles.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `INIT`  in  1  reset, asynchronous, active-low.
- `LOAD`  in  1  single-cycle pulse; captures `W_MAG`, `W_SIGN`, `B_MAG`, `B_SIGN` into the shadow registers.
- `W_MAG`  in  N*BW  lane k magnitude at bits [k*BW+BW−1 : k*BW].
- `W_SIGN`  in  N  lane sign; 1 = negative.
- `B_MAG`  in  BW  bias magnitude.
- `B_SIGN`  in  1  bias sign.
- `START`  in  1  begins a window; honoured only in IDLE.
- `CONT`  in  1  sampled on a window's last cycle; 1 = begin the next window with no gap.
- `alpha`  out  N  lane bitstreams.
- `SIGN_alpha`  out  N  active lane signs.
- `beta`  out  1  bias bitstream.
- `SIGN_beta`  out  1  active bias sign.
- `FRAME`  out  1  high on every cycle that carries a stream bit.
- `DONE`  out  1  one-cycle pulse, coincident with the last bit of each window.
- `BUSY`  out  1  high in RUN.

## Operation
- **Registers.** Shadow set (N+1 magnitudes and signs) and active set (same), plus a `pend` flag.
- **LOAD.** Writes the shadow set and sets `pend`.
- **Shadow-to-active copy.** Happens, and clears `pend`, under either condition:
  - state is IDLE and `pend` is set, on the next edge;
  - on a window's last cycle, if `pend` is set.
- **LOAD on a window's last cycle.** Shadow is written, and `pend` remains set after the copy.
- **No mid-window change.** Active values never change in the middle of a window.
- **LFSRs.**
  - One Galois LFSR per lane (N) plus one for the bias. All are BW bits and maximal-length.
  - Polynomials: BW=4: x^4+x^3+1. BW=6: x^6+x^5+1. BW=8: x^8+x^6+x^5+x^4+1.
  - Seed for lane k: 2k+1 truncated to BW bits; forced to 1 if that gives 0. Bias seed: 2N+1, same truncation and fallback.
  - An LFSR never holds 0.
- **Stream bits.** `alpha[k] = FRAME & (lfsr_k <= mag_k)`. `beta` is formed the same way from the bias LFSR and bias magnitude.
  - Over one window (a full LFSR period), the ones count equals the magnitude exactly (0 … 2^BW−1).
- **Sign outputs.** `SIGN_alpha` and `SIGN_beta` present the active signs at all times, including IDLE.
- **Window counter.** WCNT, BW bits; counts 0 … 2^BW−2 within RUN.
- **FSM states.**
  - IDLE:
    - `FRAME`=0, `BUSY`=0.
    - On `START`, the edge reseeds all LFSRs, clears WCNT and moves to RUN.
    - If `pend` is set at that edge, the copy happens on the same edge.
  - RUN:
    - `FRAME`=1, `BUSY`=1.
    - Each edge advances every LFSR and increments WCNT.
    - When WCNT = 2^BW−2, that cycle is the last: `DONE`=1.
    - At the next edge, with `CONT`=1: stay in RUN and clear WCNT. The LFSRs have wrapped to their seeds naturally.
    - At the next edge, with `CONT`=0: go to IDLE.
- **START in RUN.** Ignored.
- **START and LOAD in the same IDLE cycle.** The window uses the newly loaded values.
- **Reset (INIT low, asynchronous).**
  - State goes to IDLE.
  - WCNT=0, `pend`=0; shadow and active sets are 0.
  - LFSRs are set to their seeds.
  - All outputs 0.
  - INIT low mid-window aborts the window with no `DONE`.

## Timing
- **START to first bit.** `START` sampled high at edge t (IDLE). First bit is in cycle t..t+1, then one bit per cycle for 2^BW−1 cycles.
- **DONE.** Occurs in the final cycle of the window.
- **Outputs.** All outputs are decoded from flops only; there is no input-to-output combinational path.
- **Latency.** 1 cycle from `START` to `FRAME`.
- **Back-to-back windows.** With `CONT` held, windows are contiguous with zero gap cycles, and `FRAME` stays high.
- **Post-reset.** The first `START` after reset may be asserted in the first cycle with INIT high.

## Test plan
- BW=8, N=4, LOAD magnitudes {0, 1, 128, 255}, START, CONT=0 → per-lane ones counts {0, 1, 128, 255} over 255 `FRAME` cycles; `DONE` high only on the 255th cycle; `BUSY` falls the next cycle.
- LOAD `W_SIGN`=4'b1010, `B_SIGN`=1, `B_MAG`=64 → `SIGN_alpha`=4'b1010 and `SIGN_beta`=1 after the copy; beta ones count = 64.
- Run with lane0=10 and CONT=1. LOAD lane0=200 at WCNT=100 → window 1 counts 10, window 2 counts 200; no gap between windows; `DONE` pulses twice, 255 cycles apart.
- LOAD on the last cycle of a window with CONT=0 → next window after START uses the new values; `pend` is clear afterwards.
- Drop INIT at WCNT=50 → all outputs 0 immediately; no `DONE`. A following START produces a bit sequence identical to the first window after power-up.
- START pulsed at WCNT=20 in RUN → ignored; window ends at the original 255-cycle boundary.
